// File: rtl/mu0_loader_pkg.sv
// mu0_loader_pkg: loader state encoding and RAM sizing shared by the MU0 RAM loader.
// S_CSUM exists only when MU0_LOADER_CHECKSUM_EN is defined.
package mu0_loader_pkg;
  localparam int FRAME_HDR_BYTES = 4;
  localparam int RAM_WORDS = 4096;
  typedef enum logic [2:0] {
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef MU0_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } loader_state_t;
endpackage

// File: rtl/mu0_byte_pairer.sv
// mu0_byte_pairer: holds the HI byte and emits {hi,lo} with a one-cycle word_valid after the LO byte.
module mu0_byte_pairer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic        byte_lo,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [15:0] word
);
  logic [7:0] hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic valid_q, valid_d;
  always_comb begin
    hi_d = byte_en && !byte_lo ? byte_data : hi_q;
    word_d = byte_en && byte_lo ? {hi_q, byte_data} : word_q;
    valid_d = byte_en && byte_lo;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      word_q <= word_d;
      valid_q <= valid_d;
    end
  end
  assign word_valid = valid_q;
  assign word = word_q;
endmodule

// File: rtl/mu0_ram_loader.sv
// mu0_ram_loader: loads a framed byte stream into MU0 RAM, then hands the RAM port to the CPU.
// Define MU0_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module mu0_ram_loader
  import mu0_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              cpu_run,
  output logic              load_error
);
`ifdef MU0_LOADER_CHECKSUM_EN
  localparam loader_state_t S_LAST = S_CSUM;
`else
  localparam loader_state_t S_LAST = S_DONE;
`endif
  loader_state_t state_q, state_d;
  logic rdy_q;
  logic [7:0] hdr_q, hdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [15:0] cnt_q, cnt_d;
  logic run_q, run_d, acc, wr, own;
  logic [DATA_W-1:0] word;
  assign in_ready = rdy_q && state_q != S_DONE;
  assign acc = in_valid && in_ready;
  mu0_byte_pairer u_pair (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (acc),
    .byte_lo    (state_q == S_DATA_LO),
    .byte_data  (in_data),
    .word_valid (wr),
    .word       (word)
  );
  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    addr_d = addr_q;
    maddr_d = maddr_q;
    cnt_d = cnt_q;
    if (acc)
      case (state_q)
        S_ADDR_HI: begin hdr_d = in_data; state_d = S_ADDR_LO; end
        S_ADDR_LO: begin addr_d = ADDR_W'({hdr_q, in_data}); state_d = S_CNT_HI; end
        S_CNT_HI:  begin hdr_d = in_data; state_d = S_CNT_LO; end
        S_CNT_LO: begin
          cnt_d = {hdr_q, in_data};
          state_d = {hdr_q, in_data} == 16'd0 ? S_LAST : S_DATA_HI;
        end
        S_DATA_HI: state_d = S_DATA_LO;
        S_DATA_LO: begin
          maddr_d = addr_q;
          addr_d = addr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          state_d = cnt_q == 16'd1 ? S_LAST : S_DATA_HI;
        end
`ifdef MU0_LOADER_CHECKSUM_EN
        S_CSUM: state_d = S_DONE;
`endif
        default: ;
      endcase
    if (state_q == S_DONE && load_start) state_d = S_ADDR_HI;
    run_d = state_q == S_DONE && !load_start && !load_error;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ADDR_HI;
      rdy_q <= 1'b0;
      hdr_q <= '0;
      addr_q <= '0;
      maddr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      hdr_q <= hdr_d;
      addr_q <= addr_d;
      maddr_q <= maddr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
`ifdef MU0_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic err_q, err_d;
  always_comb begin
    csum_d = !acc ? csum_q : state_q == S_ADDR_HI ? in_data : csum_q ^ in_data;
    err_d = state_q == S_DONE && load_start ? 1'b0
          : err_q || (acc && state_q == S_CSUM && in_data != csum_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
      err_q <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q <= err_d;
    end
  end
  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif
  // The final data word's write pulse lands in the first S_DONE cycle, so the loader keeps the port for it.
  assign own = state_q == S_DONE && !wr;
  assign mem_address = own ? cpu_address : maddr_q;
  assign mem_write = own ? cpu_write : wr;
  assign mem_read = own && cpu_read;
  assign mem_writedata = own ? cpu_writedata : word;
  assign cpu_run = run_q;
endmodule

// File: tb/tb_mu0_ram_loader.sv
// tb_mu0_ram_loader: table-driven and randomized frames checked against a queue-based write model.
module tb_mu0_ram_loader;
  import mu0_loader_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, load_start, cpu_write, cpu_read;
  logic mem_write, mem_read, cpu_run, load_error;
  logic [7:0] in_data;
  logic [11:0] cpu_address, mem_address;
  logic [15:0] cpu_writedata, mem_writedata;
  int checks = 0, failures = 0;
  typedef struct packed {logic [11:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic [15:0] a16; logic [15:0] w0, w1; logic [11:0] ea0, ea1; int gap;} frm_t;
  typedef struct {logic [11:0] a; logic w, r; logic [15:0] wd; logic [11:0] ea; logic ew, er; logic [15:0] ewd;} pt_t;
  wr_t got_q[$], exp_q[$];
  logic [15:0] words[$];
  frm_t ft[4];
  pt_t pt[3];

  mu0_ram_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_start(load_start), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .cpu_writedata(cpu_writedata), .mem_address(mem_address),
    .mem_write(mem_write), .mem_read(mem_read), .mem_writedata(mem_writedata),
    .cpu_run(cpu_run), .load_error(load_error)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_write && !cpu_run && !rst) got_q.push_back({mem_address, mem_writedata});

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_data = b;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    chk("accept_ready", in_ready, 1);
    if (in_ready) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a16, input bit bad, input int maxgap);
    logic [7:0] b[$];
    int n = words.size();
    exp_q.delete();
    got_q.delete();
    b = '{a16[15:8], a16[7:0], 8'(n >> 8), 8'(n)};
    foreach (words[k]) begin
      b.push_back(words[k][15:8]);
      b.push_back(words[k][7:0]);
      exp_q.push_back('{a: 12'((int'(a16) + k) % RAM_WORDS), d: words[k]});
    end
`ifdef MU0_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      foreach (b[k]) x ^= b[k];
      b.push_back(x ^ (bad ? 8'hFF : 8'h00));
    end
`endif
    for (int i = 0; i < b.size(); i++) begin
      if (i == b.size() - 1) chk("run_busy", cpu_run, 0);
      send_byte(b[i], $urandom_range(0, maxgap));
      if (i >= FRAME_HDR_BYTES && i < FRAME_HDR_BYTES + 2 * n && i % 2 == 1) begin
        chk("wr_pulse", mem_write, 1);
        chk("wr_addr", mem_address, exp_q[(i - 5) / 2].a);
        chk("wr_data", mem_writedata, exp_q[(i - 5) / 2].d);
      end
    end
    chk("done_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("run_done", cpu_run, !bad);
    chk("err_done", load_error, bad);
    chk("wr_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) chk("wr_entry", got_q[k], exp_q[k]);
  endtask

  task automatic restart();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    chk("restart_run", cpu_run, 0);
    chk("restart_err", load_error, 0);
    chk("restart_ready", in_ready, 1);
  endtask

  initial begin
    ft[0] = '{16'h0010, 16'h1234, 16'hABCD, 12'h010, 12'h011, 0};
    ft[1] = '{16'hFFFF, 16'h1111, 16'h2222, 12'hFFF, 12'h000, 0};
    ft[2] = '{16'hFFFF, 16'h1111, 16'h2222, 12'hFFF, 12'h000, 3};
    ft[3] = '{16'h37FE, 16'hBEEF, 16'hCAFE, 12'h7FE, 12'h7FF, 2};
    pt[0] = '{12'h123, 1'b0, 1'b1, 16'h0000, 12'h123, 1'b0, 1'b1, 16'h0000};
    pt[1] = '{12'hFFF, 1'b1, 1'b0, 16'h5A5A, 12'hFFF, 1'b1, 1'b0, 16'h5A5A};
    pt[2] = '{12'h000, 1'b1, 1'b1, 16'hFFFF, 12'h000, 1'b1, 1'b1, 16'hFFFF};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; load_start = 1'b0;
    cpu_address = '0; cpu_write = 1'b0; cpu_read = 1'b0; cpu_writedata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_err", load_error, 0);
    chk("rst_addr", mem_address, 0);
    rst = 1'b0;
    #1 chk("rst_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);

    for (int t = 0; t < 4; t++) begin
      words = '{ft[t].w0, ft[t].w1};
      send_frame(ft[t].a16, 1'b0, ft[t].gap);
      chk("tbl_size", got_q.size(), 2);
      if (got_q.size() == 2) begin
        chk("tbl_a0", got_q[0].a, ft[t].ea0);
        chk("tbl_a1", got_q[1].a, ft[t].ea1);
        chk("tbl_d1", got_q[1].d, ft[t].w1);
      end
      restart();
    end

    words.delete();
    send_frame(16'h0000, 1'b0, 0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      cpu_address = pt[t].a; cpu_write = pt[t].w; cpu_read = pt[t].r; cpu_writedata = pt[t].wd;
      #1;
      chk("pt_addr", mem_address, pt[t].ea);
      chk("pt_write", mem_write, pt[t].ew);
      chk("pt_read", mem_read, pt[t].er);
      chk("pt_wdata", mem_writedata, pt[t].ewd);
    end
    @(negedge clk);
    cpu_address = '0; cpu_write = 1'b0; cpu_read = 1'b0; cpu_writedata = '0;
    restart();

    got_q.delete();
    foreach (ft[1].a16[k]) ;
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_wr", mem_write, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_nowrite", got_q.size(), 0);
    chk("midrst_ready1", in_ready, 1);
    chk("midrst_run", cpu_run, 0);
    words = '{16'h1111, 16'h2222};
    send_frame(16'hFFFF, 1'b0, 0);
    restart();

    for (int r = 0; r < 20; r++) begin
      words.delete();
      repeat ($urandom_range(0, 6)) words.push_back(16'($urandom));
      send_frame(16'($urandom), 1'b0, 3);
      restart();
    end

    words.delete();
    for (int k = 0; k < 4098; k++) words.push_back(16'(k * 7 + 3));
    send_frame(16'hAFFE, 1'b0, 0);
    restart();

`ifdef MU0_LOADER_CHECKSUM_EN
    words = '{16'h1234};
    send_frame(16'h0010, 1'b0, 0);
    restart();
    send_frame(16'h0010, 1'b1, 0);
    restart();
    words = '{16'h4321};
    send_frame(16'h0020, 1'b0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
